ysyx_2022040010_wb_stage: RTL and testbench

Write-back stage feeding the regfile write port (we/waddr/wdata) from the MEM stage. It holds one retiring instruction in a pipeline register and sign/zero-extends load data. It emits one commit pulse per retired instruction for difftest, counts retired instructions, and stops the core on ebreak.

---
 rtl/ysyx_2022040010_wb_stage_if.sv | 29 ++
 rtl/ysyx_2022040010_wb_stage.sv | 102 ++++++++++
 tb/tb_ysyx_2022040010_wb_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_2022040010_wb_stage_if.sv
// MEM -> WB handoff bus: one instruction plus its result/load descriptor and
// the WB-side ready.
interface ysyx_2022040010_wb_stage_if #(
   parameter int XLEN = 64
);
   logic            mem_valid;
   logic            mem_ready;
   logic [XLEN-1:0] mem_pc;
   logic [31:0]     mem_inst;
   logic            mem_rd_we;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_alu_res;
   logic            mem_is_load;
   logic [2:0]      mem_load_op;
   logic [2:0]      mem_addr_lo;
   logic [XLEN-1:0] mem_rdata;

   modport master (
      output mem_valid, mem_pc, mem_inst, mem_rd_we, mem_rd, mem_alu_res,
             mem_is_load, mem_load_op, mem_addr_lo, mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_valid, mem_pc, mem_inst, mem_rd_we, mem_rd, mem_alu_res,
             mem_is_load, mem_load_op, mem_addr_lo, mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/ysyx_2022040010_wb_stage.sv
// Write-back stage: one-entry WB register, load extension, regfile write,
// difftest commit pulse, retired-instruction counter and ebreak halt.
module ysyx_2022040010_wb_stage #(
   parameter int          XLEN        = 64,
   parameter int          STALL_W     = 6,
   parameter int          STALL_BIT   = 4,
   parameter logic [31:0] EBREAK_INST = 32'h00100073
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STALL_W-1:0]   stall,
   ysyx_2022040010_wb_stage_if.slave mem,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic                 commit_valid,
   output logic [XLEN-1:0]      commit_pc,
   output logic [31:0]          commit_inst,
   output logic [63:0]          retired_cnt,
   output logic                 halt
);
   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HALT = 1'b1;

   // Lane is shifted down with zero fill, so bytes beyond bit 63 read as 0.
   function automatic logic [XLEN-1:0] load_ext(
      input logic [2:0]      op,
      input logic [2:0]      lo,
      input logic [XLEN-1:0] raw
   );
      logic [XLEN-1:0] lane;
      lane = raw >> {lo, 3'b000};
      case (op)
         3'd0:    load_ext = {{(XLEN-8){lane[7]}},   lane[7:0]};
         3'd1:    load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
         3'd2:    load_ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
         3'd3:    load_ext = lane;
         3'd4:    load_ext = {{(XLEN-8){1'b0}},  lane[7:0]};
         3'd5:    load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
         3'd6:    load_ext = {{(XLEN-32){1'b0}}, lane[31:0]};
         default: load_ext = '0;
      endcase
   endfunction

   logic [0:0]      state;
   logic            vld_p1;
   logic [XLEN-1:0] pc_p1;
   logic [31:0]     inst_p1;
   logic            rd_we_p1;
   logic [4:0]      rd_p1;
   logic [XLEN-1:0] data_p1;
   logic            hold;
   logic            accept;
   logic            retire;
   logic            ebreak_p1;

   assign hold      = stall[STALL_BIT];
   assign ebreak_p1 = vld_p1 & (inst_p1 == EBREAK_INST);
   // Ready is forced low during reset so every output reads 0 while rst = 0.
   assign mem.mem_ready = rst & (state == RUN) & ~hold & ~ebreak_p1;
   assign accept    = mem.mem_valid & mem.mem_ready;
   assign retire    = vld_p1 & ~hold;

   assign rf_we        = retire & rd_we_p1 & (rd_p1 != 5'd0);
   assign rf_waddr     = rd_p1;
   assign rf_wdata     = data_p1;
   assign commit_valid = retire;
   assign commit_pc    = pc_p1;
   assign commit_inst  = inst_p1;
   assign halt         = (state == HALT);

   // MEM -> WB (p1) boundary
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         vld_p1      <= 1'b0;
         pc_p1       <= '0;
         inst_p1     <= '0;
         rd_we_p1    <= 1'b0;
         rd_p1       <= '0;
         data_p1     <= '0;
         retired_cnt <= '0;
      end else begin
         if (accept) begin
            vld_p1   <= 1'b1;
            pc_p1    <= mem.mem_pc;
            inst_p1  <= mem.mem_inst;
            rd_we_p1 <= mem.mem_rd_we;
            rd_p1    <= mem.mem_rd;
            data_p1  <= mem.mem_is_load
                        ? load_ext(mem.mem_load_op, mem.mem_addr_lo, mem.mem_rdata)
                        : mem.mem_alu_res;
         end else if (!hold) begin
            vld_p1 <= 1'b0;
         end
         if (retire) begin
            retired_cnt <= retired_cnt + 64'd1;
            if (inst_p1 == EBREAK_INST) state <= HALT;
         end
      end
   end
endmodule

// File: tb/tb_ysyx_2022040010_wb_stage.sv
// Directed bench for the write-back stage: ALU ops, load extension, stall
// hold/release, x0 writes, ebreak halt and asynchronous reset.
module tb_ysyx_2022040010_wb_stage;
   localparam logic [31:0] EBREAK = 32'h00100073;
   localparam logic [31:0] ADDI   = 32'h00100293;
   localparam logic [31:0] LOADI  = 32'h00003383;
   localparam logic [63:0] RDATA  = 64'h8877665544332211;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  stall = '0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic [31:0] commit_inst;
   logic [63:0] retired_cnt;
   logic        halt;

   int n_tests = 0;
   int n_fail  = 0;

   ysyx_2022040010_wb_stage_if #(.XLEN(64)) mem_if ();

   ysyx_2022040010_wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .mem          (mem_if.slave),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_inst  (commit_inst),
      .retired_cnt  (retired_cnt),
      .halt         (halt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                        input logic we, input logic [4:0] rd, input logic [63:0] alu,
                        input logic ld, input logic [2:0] op, input logic [2:0] lo);
      mem_if.mem_valid   = v;
      mem_if.mem_pc      = pc;
      mem_if.mem_inst    = inst;
      mem_if.mem_rd_we   = we;
      mem_if.mem_rd      = rd;
      mem_if.mem_alu_res = alu;
      mem_if.mem_is_load = ld;
      mem_if.mem_load_op = op;
      mem_if.mem_addr_lo = lo;
      mem_if.mem_rdata   = RDATA;
   endtask

   task automatic idle();
      drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 3'd0, 3'd0);
   endtask

   // Issue a load at the current negedge; at the next negedge check its write.
   task automatic do_load(input string tag, input logic [2:0] op, input logic [2:0] lo,
                          input logic [63:0] exp);
      drive(1'b1, 64'h80000040, LOADI, 1'b1, 5'd7, 64'hDEAD, 1'b1, op, lo);
      @(negedge clk);
      #1;
      check_eq({tag, "_we"}, rf_we, 1'b1);
      check_eq(tag, rf_wdata, exp);
      idle();
   endtask

   initial begin
      idle();
      // reset state
      #2;
      mem_if.mem_valid = 1'b1;
      #1;
      check_eq("rst_ready", mem_if.mem_ready, 1'b0);
      check_eq("rst_we", rf_we, 1'b0);
      check_eq("rst_commit", commit_valid, 1'b0);
      check_eq("rst_cnt", retired_cnt, 64'd0);
      check_eq("rst_halt", halt, 1'b0);
      check_eq("rst_wdata", rf_wdata, 64'd0);
      idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // back-to-back ALU ops
      drive(1'b1, 64'h80000000, ADDI, 1'b1, 5'd5, 64'h11, 1'b0, 3'd0, 3'd0);
      #1;
      check_eq("alu_ready", mem_if.mem_ready, 1'b1);
      check_eq("alu_we_pre", rf_we, 1'b0);
      @(negedge clk);
      drive(1'b1, 64'h80000004, ADDI, 1'b1, 5'd6, 64'h22, 1'b0, 3'd0, 3'd0);
      #1;
      check_eq("alu0_we", rf_we, 1'b1);
      check_eq("alu0_waddr", rf_waddr, 5'd5);
      check_eq("alu0_wdata", rf_wdata, 64'h11);
      check_eq("alu0_pc", commit_pc, 64'h80000000);
      @(negedge clk);
      idle();
      #1;
      check_eq("alu1_we", rf_we, 1'b1);
      check_eq("alu1_waddr", rf_waddr, 5'd6);
      check_eq("alu1_wdata", rf_wdata, 64'h22);
      @(negedge clk);
      #1;
      check_eq("alu_we_post", rf_we, 1'b0);
      check_eq("alu_cnt", retired_cnt, 64'd2);

      // load extension
      do_load("lb7",  3'd0, 3'd7, 64'hFFFFFFFFFFFFFF88);
      do_load("lhu2", 3'd5, 3'd2, 64'h0000000000004433);
      do_load("lw4",  3'd2, 3'd4, 64'hFFFFFFFF88776655);
      do_load("lh7",  3'd1, 3'd7, 64'h0000000000000088);
      do_load("ld0",  3'd3, 3'd0, RDATA);
      do_load("op7",  3'd7, 3'd0, 64'h0);
      @(negedge clk);
      #1;
      check_eq("load_cnt", retired_cnt, 64'd8);

      // stall hold and release
      drive(1'b1, 64'h80000100, ADDI, 1'b1, 5'd8, 64'h33, 1'b0, 3'd0, 3'd0);
      @(negedge clk);
      stall = 6'b010000;
      drive(1'b1, 64'h80000104, ADDI, 1'b1, 5'd9, 64'h44, 1'b0, 3'd0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("stall_we", rf_we, 1'b0);
         check_eq("stall_commit", commit_valid, 1'b0);
         check_eq("stall_ready", mem_if.mem_ready, 1'b0);
         @(negedge clk);
      end
      stall = '0;
      #1;
      check_eq("rel_we", rf_we, 1'b1);
      check_eq("rel_waddr", rf_waddr, 5'd8);
      check_eq("rel_commit", commit_valid, 1'b1);
      check_eq("rel_ready", mem_if.mem_ready, 1'b1);
      @(negedge clk);
      idle();
      #1;
      check_eq("rel_cnt", retired_cnt, 64'd9);
      check_eq("next_waddr", rf_waddr, 5'd9);
      check_eq("next_wdata", rf_wdata, 64'h44);
      check_eq("next_we", rf_we, 1'b1);
      @(negedge clk);
      #1;
      check_eq("next_cnt", retired_cnt, 64'd10);

      // rd = x0
      drive(1'b1, 64'h80000200, ADDI, 1'b1, 5'd0, 64'h55, 1'b0, 3'd0, 3'd0);
      @(negedge clk);
      idle();
      #1;
      check_eq("x0_we", rf_we, 1'b0);
      check_eq("x0_commit", commit_valid, 1'b1);
      @(negedge clk);
      #1;
      check_eq("x0_cnt", retired_cnt, 64'd11);

      // ebreak then add
      drive(1'b1, 64'h80000300, EBREAK, 1'b0, 5'd0, 64'h0, 1'b0, 3'd0, 3'd0);
      @(negedge clk);
      drive(1'b1, 64'h80000304, ADDI, 1'b1, 5'd10, 64'h66, 1'b0, 3'd0, 3'd0);
      #1;
      check_eq("ebr_commit", commit_valid, 1'b1);
      check_eq("ebr_inst", commit_inst, EBREAK);
      check_eq("ebr_ready", mem_if.mem_ready, 1'b0);
      check_eq("ebr_halt_pre", halt, 1'b0);
      @(negedge clk);
      #1;
      check_eq("halt", halt, 1'b1);
      check_eq("halt_ready", mem_if.mem_ready, 1'b0);
      check_eq("halt_we", rf_we, 1'b0);
      check_eq("halt_commit", commit_valid, 1'b0);
      check_eq("halt_cnt", retired_cnt, 64'd12);
      @(negedge clk);
      #1;
      check_eq("halt_we2", rf_we, 1'b0);
      check_eq("halt_commit2", commit_valid, 1'b0);
      rst = 1'b0;
      #1;
      check_eq("halt_rst", halt, 1'b0);
      check_eq("halt_rst_cnt", retired_cnt, 64'd0);
      check_eq("halt_rst_ready", mem_if.mem_ready, 1'b0);
      idle();
      @(negedge clk);
      rst = 1'b1;

      // reset while stalled
      drive(1'b1, 64'h80000400, ADDI, 1'b1, 5'd11, 64'h77, 1'b0, 3'd0, 3'd0);
      @(negedge clk);
      stall = 6'b010000;
      idle();
      #1;
      check_eq("rs_we", rf_we, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rs_we_rst", rf_we, 1'b0);
      check_eq("rs_commit_rst", commit_valid, 1'b0);
      check_eq("rs_waddr_rst", rf_waddr, 5'd0);
      stall = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("rs_we_after", rf_we, 1'b0);
      check_eq("rs_commit_after", commit_valid, 1'b0);
      drive(1'b1, 64'h80000500, ADDI, 1'b1, 5'd12, 64'h99, 1'b0, 3'd0, 3'd0);
      @(negedge clk);
      idle();
      #1;
      check_eq("rs_new_we", rf_we, 1'b1);
      check_eq("rs_new_waddr", rf_waddr, 5'd12);
      check_eq("rs_new_wdata", rf_wdata, 64'h99);
      @(negedge clk);
      #1;
      check_eq("rs_new_cnt", retired_cnt, 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
